// File: rtl/uart_sample_tx_if.sv
`default_nettype none
// ============================================================================
// uart_sample_tx_if : sample stream handshake (data/valid/ready)
// Rev 1.0
// ============================================================================
interface uart_sample_tx_if;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface
`default_nettype wire

// File: rtl/uart_sample_tx.sv
`default_nettype none
// ============================================================================
// uart_sample_tx : 16-bit samples framed as {SYNC, hi, lo} and sent as 8N1 UART
// Rev 1.0
// ============================================================================
module uart_sample_tx #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          STOP_BITS    = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    uart_sample_tx_if.slave s_if,
    output logic            ftdi_tx,
    output logic            busy,
    output logic            frame_done
);

    localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      frame_q, frame_d;
    logic [15:0]      hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             sample_ready_q, sample_ready_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;
    logic             load_frame;
    logic [7:0]       cur_byte;
    logic [2:0]       next_bit_idx;

    always_comb begin
        case (byte_idx_q)
            2'd0:    cur_byte = frame_q[23:16];
            2'd1:    cur_byte = frame_q[15:8];
            default: cur_byte = frame_q[7:0];
        endcase
    end

    assign next_bit_idx = bit_idx_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        frame_d      = frame_q;
        hold_d       = hold_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        load_frame   = 1'b0;
        accept       = s_if.sample_valid && sample_ready_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (hold_full_q) begin
                    load_frame = 1'b1;
                    byte_idx_d = 2'd0;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                    tx_d      = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = ST_STOP;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = next_bit_idx;
                        tx_d      = cur_byte[next_bit_idx];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // bit_idx doubles as the stop-bit counter while in STOP
                    if (bit_idx_q != STOP_LAST) begin
                        bit_idx_d = next_bit_idx;
                    end else if (byte_idx_q != 2'd2) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = ST_START;
                        tx_d       = 1'b0;
                    end else begin
                        frame_done_d = 1'b1;
                        if (hold_full_q) begin
                            load_frame = 1'b1;
                            byte_idx_d = 2'd0;
                            state_d    = ST_START;
                            tx_d       = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load_frame) begin
            frame_d = {SYNC_BYTE, hold_q};
        end
        if (accept) begin
            hold_d = s_if.sample_data;
        end
        // a copy and an accept in one cycle leave the new sample held
        hold_full_d    = (hold_full_q && !load_frame) || accept;
        sample_ready_d = !hold_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= 3'd0;
            byte_idx_q     <= 2'd0;
            frame_q        <= 24'd0;
            hold_q         <= 16'd0;
            hold_full_q    <= 1'b0;
            sample_ready_q <= 1'b1;
            tx_q           <= 1'b1;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            byte_idx_q     <= byte_idx_d;
            frame_q        <= frame_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            sample_ready_q <= sample_ready_d;
            tx_q           <= tx_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign s_if.sample_ready = sample_ready_q;
    assign ftdi_tx           = tx_q;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_sample_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_sample_tx : directed vectors and corner sequences for uart_sample_tx
// Rev 1.0
// ============================================================================
module tb_uart_sample_tx;

    logic clk;
    logic rst_n;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;

    uart_sample_tx_if if_a ();
    uart_sample_tx_if if_b ();

    uart_sample_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_if(if_a.slave),
        .ftdi_tx(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    uart_sample_tx #(.CLKS_PER_BIT(104), .SYNC_BYTE(8'hA5), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_if(if_b.slave),
        .ftdi_tx(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // source queues, accept edges, decoded bytes, start-bit cycles, done cycles
    logic [15:0] src_a[$], src_b[$];
    int          acc_a[$], acc_b[$];
    logic [7:0]  rx_a[$],  rx_b[$];
    int          st_a[$],  st_b[$];
    int          dn_a[$],  dn_b[$];
    logic        dnb_a[$];
    logic        pend_a = 1'b0, pend_b = 1'b0;

    initial begin
        if_a.sample_valid = 1'b0; if_a.sample_data = 16'h0;
        forever begin
            @(negedge clk);
            if (pend_a) begin pend_a = 1'b0; void'(src_a.pop_front()); end
            if (src_a.size() > 0) begin
                if_a.sample_valid = 1'b1; if_a.sample_data = src_a[0];
            end else begin
                if_a.sample_valid = 1'b0;
            end
            if (if_a.sample_valid && if_a.sample_ready && rst_n) begin
                pend_a = 1'b1; acc_a.push_back(cyc + 1);
            end
        end
    end

    initial begin
        if_b.sample_valid = 1'b0; if_b.sample_data = 16'h0;
        forever begin
            @(negedge clk);
            if (pend_b) begin pend_b = 1'b0; void'(src_b.pop_front()); end
            if (src_b.size() > 0) begin
                if_b.sample_valid = 1'b1; if_b.sample_data = src_b[0];
            end else begin
                if_b.sample_valid = 1'b0;
            end
            if (if_b.sample_valid && if_b.sample_ready && rst_n) begin
                pend_b = 1'b1; acc_b.push_back(cyc + 1);
            end
        end
    end

    function automatic logic txv(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    task automatic mon(input int w, input int cpb);
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && txv(w) == 1'b0) begin
                if (w == 0) st_a.push_back(cyc); else st_b.push_back(cyc);
                repeat (cpb / 2) @(negedge clk);
                check("start_bit_mid", 32'(txv(w)), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) @(negedge clk);
                    b[i] = txv(w);
                end
                repeat (cpb) @(negedge clk);
                check("stop_bit_mid", 32'(txv(w)), 32'd1);
                if (w == 0) rx_a.push_back(b); else rx_b.push_back(b);
            end
        end
    endtask

    initial mon(0, 4);
    initial mon(1, 104);

    initial begin
        forever begin
            @(negedge clk);
            if (done_a) begin dn_a.push_back(cyc); dnb_a.push_back(busy_a); end
            if (done_b) dn_b.push_back(cyc);
        end
    end

    task automatic clear_a();
        rx_a.delete(); st_a.delete(); acc_a.delete(); dn_a.delete(); dnb_a.delete();
    endtask

    task automatic wait_rx_a(input int n, input int budget);
        int k = 0;
        while (rx_a.size() < n && k < budget) begin @(negedge clk); k++; end
        check("rx_a_count", rx_a.size(), n);
    endtask

    // single-frame check on DUT A: bytes, 1-clk latency, 120-clk frame, one done pulse
    task automatic single_frame_a(input string tag, input logic [15:0] s,
                                  input logic [7:0] hi, input logic [7:0] lo);
        clear_a();
        src_a.push_back(s);
        wait_rx_a(3, 400);
        repeat (10) @(negedge clk);
        check({tag, "_accepts"}, acc_a.size(), 1);
        check({tag, "_done_pulses"}, dn_a.size(), 1);
        if (rx_a.size() == 3) begin
            check({tag, "_byte0"}, rx_a[0], 8'hA5);
            check({tag, "_byte1"}, rx_a[1], hi);
            check({tag, "_byte2"}, rx_a[2], lo);
        end
        if (acc_a.size() == 1 && st_a.size() >= 3) begin
            check({tag, "_start_latency"}, st_a[0] - acc_a[0], 1);
            check({tag, "_byte_stride"}, st_a[2] - st_a[0], 80);
        end
        if (dn_a.size() == 1 && st_a.size() >= 1) begin
            check({tag, "_frame_len"}, dn_a[0] - st_a[0], 120);
            check({tag, "_busy_at_done"}, 32'(dnb_a[0]), 0);
        end
        check({tag, "_idle_busy"}, 32'(busy_a), 0);
        check({tag, "_idle_ready"}, 32'(if_a.sample_ready), 1);
    endtask

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] exp_bytes[9];
        logic       saw_low;
        int         k;

        vecs[0] = '{16'h1234, 8'h12, 8'h34};
        vecs[1] = '{16'h0000, 8'h00, 8'h00};
        vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
        vecs[3] = '{16'h8001, 8'h80, 8'h01};
        vecs[4] = '{16'h5AC3, 8'h5A, 8'hC3};

        // reset state and quiet idle
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx_a), 1);
        check("rst_ready", 32'(if_a.sample_ready), 1);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        rst_n = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_a == 1'b0) saw_low = 1'b1;
        end
        check("idle_tx_high", 32'(saw_low), 0);

        for (int i = 0; i < 5; i++) begin
            single_frame_a($sformatf("vec%0d", i), vecs[i].sample, vecs[i].hi, vecs[i].lo);
        end

        // back-to-back frames with valid held
        clear_a();
        src_a.push_back(16'h8001);
        src_a.push_back(16'h7FFE);
        wait_rx_a(6, 800);
        repeat (10) @(negedge clk);
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h80; exp_bytes[2] = 8'h01;
        exp_bytes[3] = 8'hA5; exp_bytes[4] = 8'h7F; exp_bytes[5] = 8'hFE;
        if (rx_a.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("b2b_byte%0d", i), rx_a[i], exp_bytes[i]);
        check("b2b_accepts", acc_a.size(), 2);
        check("b2b_done_pulses", dn_a.size(), 2);
        if (acc_a.size() == 2 && st_a.size() == 6 && dn_a.size() == 2) begin
            check("b2b_second_accept", acc_a[1] - st_a[0], 1);
            check("b2b_no_gap", st_a[3] - st_a[0], 120);
            check("b2b_done1", dn_a[0] - st_a[0], 120);
            check("b2b_done2", dn_a[1] - st_a[0], 240);
            check("b2b_busy_held", 32'(dnb_a[0]), 1);
            check("b2b_busy_fall", 32'(dnb_a[1]), 0);
        end

        // backpressure with three queued samples
        clear_a();
        src_a.push_back(16'hA1B2);
        src_a.push_back(16'hC3D4);
        src_a.push_back(16'hE5F6);
        wait_rx_a(9, 1200);
        repeat (10) @(negedge clk);
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'hA1; exp_bytes[2] = 8'hB2;
        exp_bytes[3] = 8'hA5; exp_bytes[4] = 8'hC3; exp_bytes[5] = 8'hD4;
        exp_bytes[6] = 8'hA5; exp_bytes[7] = 8'hE5; exp_bytes[8] = 8'hF6;
        if (rx_a.size() == 9)
            for (int i = 0; i < 9; i++) check($sformatf("bp_byte%0d", i), rx_a[i], exp_bytes[i]);
        check("bp_accepts", acc_a.size(), 3);
        check("bp_done_pulses", dn_a.size(), 3);
        if (acc_a.size() == 3 && st_a.size() >= 1) begin
            check("bp_accept2", acc_a[1] - st_a[0], 1);
            check("bp_accept3", acc_a[2] - st_a[0], 121);
        end

        // reset during DATA bit 3 of byte 1
        clear_a();
        src_a.push_back(16'h00C3);
        k = 0;
        while (st_a.size() < 1 && k < 100) begin @(negedge clk); k++; end
        check("mid_rst_frame_started", st_a.size(), 1);
        if (st_a.size() >= 1) begin
            k = 0;
            while (cyc < st_a[0] + 57 && k < 200) begin @(negedge clk); k++; end
            check("mid_rst_pre_tx", 32'(tx_a), 0);
            check("mid_rst_pre_busy", 32'(busy_a), 1);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_a), 1);
        check("mid_rst_busy", 32'(busy_a), 0);
        check("mid_rst_ready", 32'(if_a.sample_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        single_frame_a("post_rst", 16'h2468, 8'h24, 8'h68);

        // two stop bits at full baud divisor
        rx_b.delete(); st_b.delete(); acc_b.delete(); dn_b.delete();
        src_b.push_back(16'hFFFF);
        k = 0;
        while (rx_b.size() < 3 && k < 5000) begin @(negedge clk); k++; end
        check("sb2_rx_count", rx_b.size(), 3);
        repeat (250) @(negedge clk);
        if (rx_b.size() == 3) begin
            check("sb2_byte0", rx_b[0], 8'hA5);
            check("sb2_byte1", rx_b[1], 8'hFF);
            check("sb2_byte2", rx_b[2], 8'hFF);
        end
        check("sb2_done_pulses", dn_b.size(), 1);
        if (st_b.size() == 3 && acc_b.size() == 1 && dn_b.size() == 1) begin
            check("sb2_latency", st_b[0] - acc_b[0], 1);
            check("sb2_byte_stride", st_b[1] - st_b[0], 1144);
            check("sb2_byte_stride2", st_b[2] - st_b[1], 1144);
            check("sb2_frame_len", dn_b[0] - st_b[0], 3432);
        end
        check("sb2_idle_busy", 32'(busy_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
